branch_predict_unit: RTL and testbench

//  Front-end counterpart of EX-stage branch resolution. Holds a direct-mapped table
//  of 2-bit saturating counters (BHT) that supplies a taken prediction to IF.

---
 rtl/branch_predict_unit.sv | 115 +++++++++++
 tb/tb_branch_predict_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped 2-bit BHT, trained from EX resolution, with a registered redirect/flush pulse.
// Optional branch target buffer enabled by defining BPU_BTB_EN.
module branch_predict_unit #(
  parameter int         PC_W     = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [1:0]      ex_inst_type,
  input  logic            ex_branch_taken,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_target,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush
);

  localparam int ENTRIES = 1 << IDX_W;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  logic [1:0]      cnt_q [ENTRIES];
  logic [1:0]      cnt_d [ENTRIES];
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             accept, is_branch, is_jalr, mispredict;

  assign if_idx     = if_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  // The instruction sitting in EX while a redirect is issued is wrong-path.
  assign accept     = ex_valid & ~redirect_valid_q;
  assign is_branch  = (ex_inst_type == 2'b10);
  assign is_jalr    = (ex_inst_type == 2'b01);
  assign mispredict = (ex_branch_taken != ex_pred_taken);

  logic unused_if_bits;
  assign unused_if_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  always_comb begin
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (accept && is_branch) begin
      cnt_d[ex_idx] = sat_update(cnt_q[ex_idx], ex_branch_taken);
      if (mispredict) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = ex_branch_taken ? ex_target : ex_pc + PC_W'(4);
      end
    end else if (accept && is_jalr) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = {ex_target[PC_W-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef BPU_BTB_EN
  logic [PC_W-1:0] btb_tgt_q [ENTRIES];
  logic [PC_W-1:0] btb_tgt_d [ENTRIES];
  logic            btb_vld_q [ENTRIES];
  logic            btb_vld_d [ENTRIES];

  always_comb begin
    btb_tgt_d = btb_tgt_q;
    btb_vld_d = btb_vld_q;
    if (accept && is_branch && ex_branch_taken) begin
      btb_tgt_d[ex_idx] = ex_target;
      btb_vld_d[ex_idx] = 1'b1;
    end
  end

  // Targets are qualified by the valid bits, so only those need a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) btb_vld_q[i] <= 1'b0;
    end else begin
      btb_vld_q <= btb_vld_d;
    end
    btb_tgt_q <= btb_tgt_d;
  end

  assign pred_taken  = if_valid & cnt_q[if_idx][1] & btb_vld_q[if_idx];
  assign pred_target = btb_vld_q[if_idx] ? btb_tgt_q[if_idx] : '0;
`else
  assign pred_taken  = if_valid & cnt_q[if_idx][1];
  assign pred_target = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven bench for branch_predict_unit with a redirect scoreboard.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_inst_type;
  logic        ex_branch_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  branch_predict_unit #(.PC_W(32), .IDX_W(6), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst_type(ex_inst_type),
    .ex_branch_taken(ex_branch_taken), .ex_pred_taken(ex_pred_taken),
    .ex_target(ex_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        ifv;
    logic [31:0] ifpc;
    logic        exv;
    logic [31:0] expc;
    logic [1:0]  typ;
    logic        tk;
    logic        pr;
    logic [31:0] tgt;
    logic        e_pt;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic r, logic ifv, logic [31:0] ifpc, logic exv,
                              logic [31:0] expc, logic [1:0] typ, logic tk, logic pr,
                              logic [31:0] tgt, logic e_pt, logic e_rv, logic [31:0] e_rpc);
    vec_t v;
    v.rst_n = r; v.ifv = ifv; v.ifpc = ifpc; v.exv = exv; v.expc = expc; v.typ = typ;
    v.tk = tk; v.pr = pr; v.tgt = tgt; v.e_pt = e_pt; v.e_rv = e_rv; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle: inputs at negedge, combinational prediction checked before the
  // edge, registered redirect outputs popped from the scoreboard after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n           = v.rst_n;
    if_valid        = v.ifv;
    if_pc           = v.ifpc;
    ex_valid        = v.exv;
    ex_pc           = v.expc;
    ex_inst_type    = v.typ;
    ex_branch_taken = v.tk;
    ex_pred_taken   = v.pr;
    ex_target       = v.tgt;
    #1;
    chk({tag, " pred_taken"}, {31'b0, pred_taken}, {31'b0, v.e_pt});
    chk({tag, " pred_target"}, pred_target, 32'h0);
    e.rv  = v.e_rv;
    e.rpc = v.e_rpc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      chk({tag, " redirect_valid"}, {31'b0, redirect_valid}, {31'b0, e.rv});
      chk({tag, " flush"}, {31'b0, flush}, {31'b0, e.rv});
      chk({tag, " redirect_pc"}, redirect_pc, e.rpc);
    end
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0;
    ex_inst_type = 2'b00; ex_branch_taken = 1'b0; ex_pred_taken = 1'b0; ex_target = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst flush", {31'b0, flush}, 32'h0);
    chk("rst redirect_pc", redirect_pc, 32'h0);
    if_valid = 1'b1;
    if_pc = 32'h0;          #1; chk("rst pred 0x0", {31'b0, pred_taken}, 32'h0);
    if_pc = 32'h100;        #1; chk("rst pred 0x100", {31'b0, pred_taken}, 32'h0);
    if_pc = 32'hFFFF_FFFC;  #1; chk("rst pred 0xfffffffc", {31'b0, pred_taken}, 32'h0);

    //              rst ifv ifpc           exv expc           typ    tk pr tgt           pt rv rpc
    tbl.push_back(mk(1, 1, 32'h100,       0, 32'h0,         2'b00, 0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'h204,       1, 32'h100,       2'b00, 1, 0, 32'h80,       0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'h100,       1, 32'h100,       2'b11, 1, 0, 32'h80,       0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'h100,       1, 32'h100,       2'b10, 1, 0, 32'h80,       0, 1, 32'h80));
    tbl.push_back(mk(1, 1, 32'h100,       0, 32'h0,         2'b00, 0, 0, 32'h0,        1, 0, 32'h80));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 1, 32'h100,     1, 32'h100,       2'b10, 1, 1, 32'h80,       1, 0, 32'h80));
    tbl.push_back(mk(1, 1, 32'h100,       1, 32'h100,       2'b10, 0, 1, 32'h80,       1, 1, 32'h104));
    tbl.push_back(mk(1, 1, 32'h100,       0, 32'h0,         2'b00, 0, 0, 32'h0,        1, 0, 32'h104));
    tbl.push_back(mk(1, 1, 32'h100,       1, 32'h100,       2'b10, 0, 1, 32'h80,       1, 1, 32'h104));
    tbl.push_back(mk(1, 1, 32'h100,       0, 32'h0,         2'b00, 0, 0, 32'h0,        0, 0, 32'h104));
    tbl.push_back(mk(1, 1, 32'h40,        1, 32'h40,        2'b01, 0, 0, 32'h205,      0, 1, 32'h204));
    tbl.push_back(mk(1, 1, 32'h40,        0, 32'h0,         2'b00, 0, 0, 32'h0,        0, 0, 32'h204));
    tbl.push_back(mk(1, 1, 32'h40,        0, 32'h0,         2'b00, 0, 0, 32'h0,        0, 0, 32'h204));
    tbl.push_back(mk(1, 1, 32'h80,        1, 32'h80,        2'b10, 1, 0, 32'h300,      0, 1, 32'h300));
    tbl.push_back(mk(1, 1, 32'h40,        1, 32'h40,        2'b10, 1, 0, 32'h500,      0, 0, 32'h300));
    tbl.push_back(mk(1, 1, 32'h40,        0, 32'h0,         2'b00, 0, 0, 32'h0,        0, 0, 32'h300));
    tbl.push_back(mk(1, 1, 32'h80,        0, 32'h0,         2'b00, 0, 0, 32'h0,        1, 0, 32'h300));
    tbl.push_back(mk(1, 0, 32'h80,        1, 32'hFFFF_FFFC, 2'b10, 0, 1, 32'h10,       0, 1, 32'h0));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 32'h0,         2'b00, 0, 0, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'hFC,        1, 32'hFFFF_FFFC, 2'b10, 0, 0, 32'h10,       0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 2'b10, 1, 0, 32'h7,        0, 1, 32'h7));
    tbl.push_back(mk(1, 1, 32'hFC,        0, 32'h0,         2'b00, 0, 0, 32'h0,        0, 0, 32'h7));
    tbl.push_back(mk(1, 1, 32'h80,        0, 32'h40,        2'b01, 0, 0, 32'h999,      1, 0, 32'h7));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted in the cycle a mispredict resolves: no pulse, table reinitialised.
    apply(mk(0, 1, 32'h80,  1, 32'h80,  2'b10, 1, 0, 32'h444, 1, 0, 32'h0), "rst_vs_mispredict");
    apply(mk(1, 1, 32'h80,  0, 32'h0,   2'b00, 0, 0, 32'h0,   0, 0, 32'h0), "after_rst_0x80");
    // Reset during the pulse cycle clears the pulse and the trained counter.
    apply(mk(1, 1, 32'h100, 1, 32'h100, 2'b10, 1, 0, 32'h60,  0, 1, 32'h60), "pre_rst_mispredict");
    apply(mk(0, 1, 32'h100, 0, 32'h0,   2'b00, 0, 0, 32'h0,   1, 0, 32'h0), "rst_in_pulse");
    apply(mk(1, 1, 32'h100, 0, 32'h0,   2'b00, 0, 0, 32'h0,   0, 0, 32'h0), "after_rst_0x100");

    chk("scoreboard drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
